// File: rtl/mips_program_loader.sv
// Boot loader for pipe_MIPS32: takes a header/payload/checksum word stream, writes
// sections into unified memory, then releases the core at the terminator's entry PC.
module mips_program_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_run,
  output logic [DATA_W-1:0] pc_init,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  // state  | meaning
  // S_HDR  | waiting for a section header or terminator
  // S_DATA | writing payload words of the current section
  // S_CHK  | expecting the section checksum word
  // S_DONE | load complete, core released (until reset)
  // S_ERR  | range or checksum failure, core held (until reset)
  typedef enum logic [2:0] {S_HDR, S_DATA, S_CHK, S_DONE, S_ERR} state_t;

  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

  state_t            state, state_nxt;
  logic              armed;
  logic              xfer;
  logic [15:0]       hdr_base;
  logic [15:0]       hdr_count;
  logic [16:0]       hdr_end;
  logic              term_ok;
  logic [ADDR_W-1:0] ptr;
  logic [15:0]       remaining;
  logic [DATA_W-1:0] acc;

  assign hdr_base  = ld_data[DATA_W-1 -: 16];
  assign hdr_count = ld_data[15:0];
  assign hdr_end   = {1'b0, hdr_base} + {1'b0, hdr_count};
  assign term_ok   = ({1'b0, hdr_base} < DEPTH);

  // armed keeps ready low until the first edge after reset release
  assign ld_ready  = armed & ((state == S_HDR) | (state == S_DATA) | (state == S_CHK));
  assign xfer      = ld_valid & ld_ready;
  assign cpu_run   = (state == S_DONE);
  assign load_done = (state == S_DONE);
  assign load_err  = (state == S_ERR);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) state <= S_HDR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HDR: begin
        if (xfer) begin
          if (hdr_count != 16'd0) state_nxt = (hdr_end <= DEPTH) ? S_DATA : S_ERR;
          else                    state_nxt = term_ok ? S_DONE : S_ERR;
        end
      end
      S_DATA: begin
        if (xfer && remaining == 16'd1) state_nxt = S_CHK;
      end
      S_CHK: begin
        if (xfer) state_nxt = (ld_data == acc) ? S_HDR : S_ERR;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      armed        <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      pc_init      <= '0;
      words_loaded <= '0;
      ptr          <= '0;
      remaining    <= '0;
      acc          <= '0;
    end else begin
      armed  <= 1'b1;
      mem_we <= 1'b0;
      if (xfer) begin
        case (state)
          S_HDR: begin
            acc       <= ld_data;
            ptr       <= hdr_base[ADDR_W-1:0];
            remaining <= hdr_count;
            if (hdr_count == 16'd0 && term_ok) pc_init <= DATA_W'(hdr_base);
          end
          S_DATA: begin
            mem_we    <= 1'b1;
            mem_addr  <= ptr;
            mem_wdata <= ld_data;
            ptr       <= ptr + 1'b1;
            acc       <= acc ^ ld_data;
            remaining <= remaining - 16'd1;
            if (words_loaded != '1) words_loaded <= words_loaded + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips_program_loader.sv
// Scoreboard bench for mips_program_loader: expected memory writes are queued as
// payload words are accepted and matched against mem_we pulses.
module tb_mips_program_loader;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b1;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_data = '0;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_run;
  logic [31:0] pc_init;
  logic        load_done;
  logic        load_err;
  logic [10:0] words_loaded;

  mips_program_loader #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk1(clk1), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_run(cpu_run), .pc_init(pc_init), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    int          due;
    logic [9:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [31:0] t1w [8] = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                           32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};

  always @(posedge clk1) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk1) begin
    if (mem_we) begin
      if (exp_q.size() == 0) chk("unexpected_mem_we", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("we_latency", cyc, e.due);
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_wdata", mem_wdata, e.data);
      end
    end
  end

  task automatic put_word(input logic [31:0] d, input bit pay, input logic [9:0] addr,
                          input bit gaps);
    bit ok;
    if (gaps) begin
      for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
        ld_valid = 1'b0;
        ld_data  = $urandom;
        @(posedge clk1); #1;
      end
    end
    ld_valid = 1'b1;
    ld_data  = d;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk1);
      if (ld_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    else if (pay) exp_q.push_back('{cyc + 1, addr, d});
    @(posedge clk1); #1;
    ld_valid = 1'b0;
    ld_data  = $urandom;
  endtask

  task automatic do_reset();
    ld_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk1);
    rst_n = 1'b1;
    @(posedge clk1); #1;
  endtask

  task automatic send_t1(input bit gaps);
    logic [31:0] ck;
    ck = 32'h0000_0008;
    put_word(32'h0000_0008, 0, 10'd0, gaps);
    for (int i = 0; i < 8; i++) begin
      put_word(t1w[i], 1, 10'(i), gaps);
      ck ^= t1w[i];
    end
    put_word(ck, 0, 10'd0, gaps);
    put_word(32'h0078_0001, 0, 10'd0, gaps);
    put_word(32'd85, 1, 10'd120, gaps);
    put_word(32'h0078_0001 ^ 32'd85, 0, 10'd0, gaps);
    put_word(32'h0000_0000, 0, 10'd0, gaps);
  endtask

  task automatic check_t1_final(input string tag);
    @(negedge clk1);
    chk({tag, "_cpu_run"}, cpu_run, 1);
    chk({tag, "_pc_init"}, pc_init, 0);
    chk({tag, "_load_done"}, load_done, 1);
    chk({tag, "_load_err"}, load_err, 0);
    chk({tag, "_words_loaded"}, words_loaded, 9);
    chk({tag, "_ld_ready"}, ld_ready, 0);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ld_ready"}, ld_ready, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_cpu_run"}, cpu_run, 0);
    chk({tag, "_pc_init"}, pc_init, 0);
    chk({tag, "_load_done"}, load_done, 0);
    chk({tag, "_load_err"}, load_err, 0);
    chk({tag, "_words_loaded"}, words_loaded, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk1);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(posedge clk1); #1;
    chk("rst_ready_after_release", ld_ready, 1);

    // 1: two sections and terminator
    send_t1(0);
    check_t1_final("t1");

    // 2: bad checksum
    do_reset();
    put_word(32'h0010_0002, 0, 10'd0, 0);
    put_word(32'd1, 1, 10'd16, 0);
    put_word(32'd2, 1, 10'd17, 0);
    put_word(32'd0, 0, 10'd0, 0);
    @(negedge clk1);
    chk("t2_load_err", load_err, 1);
    chk("t2_cpu_run", cpu_run, 0);
    chk("t2_words_loaded", words_loaded, 2);
    repeat (3) @(negedge clk1);
    chk("t2_ready_stuck_low", ld_ready, 0);
    chk("t2_sb_empty", exp_q.size(), 0);

    // 3: range overflow, then exact-fit last word
    do_reset();
    put_word(32'h03FF_0002, 0, 10'd0, 0);
    repeat (3) @(negedge clk1);
    chk("t3_range_err", load_err, 1);
    chk("t3_no_writes", words_loaded, 0);
    do_reset();
    put_word(32'h03FF_0001, 0, 10'd0, 0);
    put_word(32'hDEAD_BEEF, 1, 10'd1023, 0);
    put_word(32'h03FF_0001 ^ 32'hDEAD_BEEF, 0, 10'd0, 0);
    put_word(32'h0040_0000, 0, 10'd0, 0);
    @(negedge clk1);
    chk("t3_load_done", load_done, 1);
    chk("t3_pc_init", pc_init, 32'h40);
    chk("t3_cpu_run", cpu_run, 1);
    chk("t3_sb_empty", exp_q.size(), 0);

    // 4: test 1 stream with random valid gaps
    do_reset();
    send_t1(1);
    check_t1_final("t4");

    // 5: reset mid-section, then full reload
    do_reset();
    put_word(32'h0000_0008, 0, 10'd0, 0);
    for (int i = 0; i < 3; i++) put_word(t1w[i], 1, 10'(i), 0);
    @(negedge clk1);
    chk("t5_partial_count", words_loaded, 3);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("t5_async");
    chk("t5_sb_empty", exp_q.size(), 0);
    @(negedge clk1);
    rst_n = 1'b1;
    @(posedge clk1); #1;
    chk("t5_ready_after_release", ld_ready, 1);
    send_t1(0);
    check_t1_final("t5");

    // 6: terminator base out of range
    do_reset();
    put_word(32'h0400_0000, 0, 10'd0, 0);
    @(negedge clk1);
    chk("t6_load_err", load_err, 1);
    chk("t6_cpu_run", cpu_run, 0);
    chk("t6_load_done", load_done, 0);
    chk("t6_pc_init", pc_init, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
